// File: rtl/mult_seq_controlunit.sv
// Control FSM for the sequential shift-add multiplier: operand handshake, WIDTH shift/add
// iterations, then result hold until acknowledged. Define EARLY_TERM_EN to stop once multiplier_zero.
module mult_seq_controlunit #(
  parameter  int WIDTH = 8,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inputdata_ready,
  output logic          inputdata_ack,
  output logic          loaddata,
  output logic          clear_acc,
  input  logic          multiplier_lsb,
  input  logic          multiplier_zero,
  output logic          add_en,
  output logic          shift_en,
  output logic [CW-1:0] iter_count,
  output logic          busy,
  output logic          result_valid,
  input  logic          result_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state, state_nxt;
  logic       last_iter, early_stop;

  assign last_iter = (iter_count == CW'(WIDTH - 1));

`ifdef EARLY_TERM_EN
  assign early_stop = multiplier_zero;
`else
  logic unused_zero;
  assign unused_zero = multiplier_zero;
  assign early_stop  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inputdata_ready) state_nxt = LOAD;
      LOAD:    state_nxt = CALC;
      CALC:    if (last_iter || early_stop) state_nxt = DONE;
      DONE:    if (result_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Counter freezes on the exit cycle so DONE reports the last iteration executed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      iter_count <= '0;
    else if (state == LOAD)
      iter_count <= '0;
    else if (state == CALC && !last_iter && !early_stop)
      iter_count <= iter_count + CW'(1);
  end

  assign inputdata_ack = (state == IDLE);
  assign loaddata      = (state == LOAD);
  assign clear_acc     = (state == LOAD);
  assign shift_en      = (state == CALC);
  assign add_en        = (state == CALC) && multiplier_lsb;
  assign busy          = (state == LOAD) || (state == CALC);
  assign result_valid  = (state == DONE);

endmodule

// File: tb/tb_mult_seq_controlunit.sv
// Randomized bench for mult_seq_controlunit: per-cycle timeline model of one multiply,
// plus a WIDTH=1 instance.
module tb_mult_seq_controlunit;

  logic       clk = 1'b0, reset = 1'b0;
  logic       rdy = 0, lsb = 0, zero = 0, rack = 0;
  logic       ack, load, clr, add, shift, busy, rv;
  logic [2:0] iter;
  logic       rdy1 = 0, lsb1 = 0, rack1 = 0;
  logic       ack1, load1, clr1, add1, shift1, busy1, rv1;
  logic [0:0] iter1;
  int         errors = 0, checks = 0;

  localparam logic [5:0] S_IDLE = 6'b100000, S_LOAD = 6'b011010,
                         S_CALC = 6'b000110, S_DONE = 6'b000001;
  wire [5:0] outs  = {ack, load, clr, shift, busy, rv};
  wire [5:0] outs1 = {ack1, load1, clr1, shift1, busy1, rv1};

  always #5 clk = ~clk;

  mult_seq_controlunit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .inputdata_ready(rdy), .inputdata_ack(ack),
    .loaddata(load), .clear_acc(clr), .multiplier_lsb(lsb), .multiplier_zero(zero),
    .add_en(add), .shift_en(shift), .iter_count(iter), .busy(busy),
    .result_valid(rv), .result_ack(rack));

  mult_seq_controlunit #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .inputdata_ready(rdy1), .inputdata_ack(ack1),
    .loaddata(load1), .clear_acc(clr1), .multiplier_lsb(lsb1), .multiplier_zero(1'b0),
    .add_en(add1), .shift_en(shift1), .iter_count(iter1), .busy(busy1),
    .result_valid(rv1), .result_ack(rack1));

  // Must be called at a negedge with the DUT in IDLE. Model: accept at edge T, LOAD in T+1,
  // CALC for ncalc cycles with iter=i and add=m[i], DONE until the ack edge, then IDLE.
  task automatic run_op(input logic [7:0] m, input int ack_dly, input bit hold_req);
    int ncalc;
    bit found;
    ncalc = 8;
    found = 0;
`ifdef EARLY_TERM_EN
    for (int i = 0; i < 8; i++)
      if (!found && (m >> i) == 8'd0) begin ncalc = i + 1; found = 1; end
`endif
    checks++;
    if (outs !== S_IDLE) begin errors++; $display("FAIL op_idle_start: got %b want %b", outs, S_IDLE); end
    rdy = 1; rack = 1'($urandom % 2);
    @(posedge clk); @(negedge clk);
    rdy = 1'($urandom % 2); rack = 1'($urandom % 2); zero = 0; lsb = 1'($urandom % 2);
    #1;
    checks++;
    if ({outs, add} !== {S_LOAD, 1'b0}) begin errors++; $display("FAIL op_load: got %b want %b", {outs, add}, {S_LOAD, 1'b0}); end
    for (int i = 0; i < ncalc; i++) begin
      @(posedge clk); @(negedge clk);
      lsb = m[i]; zero = ((m >> i) == 8'd0); rack = 1'($urandom % 2); rdy = 1'($urandom % 2);
      #1;
      checks++;
      if ({outs, add, iter} !== {S_CALC, m[i], 3'(i)}) begin
        errors++; $display("FAIL op_calc[%0d]: got %b want %b", i, {outs, add, iter}, {S_CALC, m[i], 3'(i)});
      end
    end
    for (int d = 0; d <= ack_dly; d++) begin
      @(posedge clk); @(negedge clk);
      lsb = 1'($urandom % 2); zero = 1'($urandom % 2);
      rdy = hold_req ? 1'b1 : 1'($urandom % 2);
      rack = (d == ack_dly);
      #1;
      checks++;
      if ({outs, add, iter} !== {S_DONE, 1'b0, 3'(ncalc - 1)}) begin
        errors++; $display("FAIL op_done[%0d]: got %b want %b", d, {outs, add, iter}, {S_DONE, 1'b0, 3'(ncalc - 1)});
      end
    end
    @(posedge clk); @(negedge clk);
    rack = 0;
    #1;
    checks++;
    if (outs !== S_IDLE) begin errors++; $display("FAIL op_idle_end: got %b want %b", outs, S_IDLE); end
  endtask

  task automatic test_reset;
    #2 reset = 1;
    #2;
    checks++;
    if ({outs, add, iter} !== {S_IDLE, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_state: got %b want %b", {outs, add, iter}, {S_IDLE, 1'b0, 3'd0});
    end
    checks++;
    if ({outs1, add1, iter1} !== {S_IDLE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state_w1: got %b want %b", {outs1, add1, iter1}, {S_IDLE, 1'b0, 1'b0});
    end
    @(negedge clk) reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_op(8'hA5, 0, 0);
    rdy = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    run_op(8'($urandom), 5, 1);
    run_op(8'h3C, 1, 0);
    rdy = 0;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      run_op(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom % 2));
      if ($urandom % 2) begin
        rdy = 0;
        repeat (2) @(negedge clk);
      end
    end
    rdy = 0;
    @(negedge clk);
  endtask

  task automatic test_early_term;
    run_op(8'h03, 0, 0);
    run_op(8'h00, 2, 0);
    rdy = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    rdy = 1;
    @(posedge clk); @(negedge clk);
    rdy = 0; lsb = 1; zero = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({outs, iter} !== {S_CALC, 3'd3}) begin errors++; $display("FAIL reset_mid_pre: got %b want %b", {outs, iter}, {S_CALC, 3'd3}); end
    #2 reset = 1;
    #1;
    checks++;
    if ({outs, add, iter} !== {S_IDLE, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_mid: got %b want %b", {outs, add, iter}, {S_IDLE, 1'b0, 3'd0});
    end
    @(negedge clk) reset = 0;
    @(negedge clk);
    checks++;
    if ({outs, iter} !== {S_IDLE, 3'd0}) begin errors++; $display("FAIL reset_mid_post: got %b want %b", {outs, iter}, {S_IDLE, 3'd0}); end
    lsb = 0;
  endtask

  task automatic test_width1;
    checks++;
    if (outs1 !== S_IDLE) begin errors++; $display("FAIL w1_idle: got %b want %b", outs1, S_IDLE); end
    rdy1 = 1;
    @(posedge clk); @(negedge clk);
    rdy1 = 0; lsb1 = 1;
    #1;
    checks++;
    if ({outs1, add1} !== {S_LOAD, 1'b0}) begin errors++; $display("FAIL w1_load: got %b want %b", {outs1, add1}, {S_LOAD, 1'b0}); end
    @(posedge clk); @(negedge clk);
    #1;
    checks++;
    if ({outs1, add1, iter1} !== {S_CALC, 1'b1, 1'b0}) begin
      errors++; $display("FAIL w1_calc: got %b want %b", {outs1, add1, iter1}, {S_CALC, 1'b1, 1'b0});
    end
    @(posedge clk); @(negedge clk);
    rack1 = 1;
    #1;
    checks++;
    if ({outs1, add1, iter1} !== {S_DONE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL w1_done: got %b want %b", {outs1, add1, iter1}, {S_DONE, 1'b0, 1'b0});
    end
    @(posedge clk); @(negedge clk);
    rack1 = 0; lsb1 = 0;
    checks++;
    if (outs1 !== S_IDLE) begin errors++; $display("FAIL w1_idle_end: got %b want %b", outs1, S_IDLE); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_early_term;
    test_random;
    test_reset_mid;
    test_width1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
